serial_add_sub: RTL
===================

# serial_add_sub

Bit-serial two's-complement adder/subtractor producing the same result as the 8-bit ripple carry adder, plus a subtract direction, using one full-adder slice and processing one bit per clock, LSB first. It sits beside the parallel adder as the area-reduced arithmetic unit. It also serves as a cycle-accurate cross-check of the parallel adder in self-checking benches. Operands are captured on a start/done handshake, and the result is held until the next operation completes.

## Interface

- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 2.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or on the done cycle.
- sub  input  1  operation select: 0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  first operand; captured with start.
- b  input  WIDTH  second operand; captured with start.
- cin  input  1  add mode: carry-in; sub mode: borrow-in; captured with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result and cout become valid.
- result  output  WIDTH  registered result, held between operations.
- cout  output  1  registered carry-out; in sub mode 1 = no borrow.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_SUB_OVF_EN.

## Operation

- Arithmetic, computed modulo 2^(WIDTH+1):
  - Add: {cout,result} = a + b + cin.
  - Sub: {cout,result} = a + ~b + !cin, which equals a − b − cin with cout = not-borrow.
- Datapath:
  - Operand shift registers feed the LSBs to one full adder.
  - The carry flop initialises to cin in add mode and to !cin in sub mode.
  - The b bit is inverted in sub mode.
  - Sum bits shift into an internal accumulator from the MSB end.
- FSM states: IDLE, RUN.
  - IDLE → RUN on start: latch a, b, sub and the initial carry; clear the bit counter.
  - RUN: one bit per cycle; the counter goes 0..WIDTH−1.
  - RUN → IDLE after bit WIDTH−1. On that edge, result ← accumulator and cout ← final carry; done pulses for the following cycle.
- start while in RUN is ignored; the captured operands are not disturbed.
- start asserted during the done cycle is accepted, so operations can run back-to-back.
- result and cout change only on completion. During RUN they keep the previous operation's values.
- rst_n low at any time, including mid-operation:
  - All state clears immediately; FSM goes to IDLE.
  - No done is produced for the aborted operation.

## Timing

- Reset values: busy=0, done=0, result=0, cout=0, ovf=0; FSM = IDLE.
- start sampled high at edge E:
  - busy is high from after E through after edge E+WIDTH−1.
  - At edge E+WIDTH, busy falls, done rises for exactly one cycle, and result/cout/ovf update.
- Latency from start sample to done is WIDTH cycles; for WIDTH=8, done is high in the 8th cycle after the start cycle.
- Throughput: one operation per WIDTH cycles.
- done and busy are never high in the same cycle.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Configuration

- SERIAL_ADD_SUB_OVF_EN defined:
  - The ovf port exists.
  - ovf = carry into MSB XOR carry out of MSB, registered on completion and held like result.
  - Reset value is 0.
- SERIAL_ADD_SUB_OVF_EN undefined:
  - No ovf port and no overflow logic.
  - All other behaviour is identical.

## Test plan

- Add, carry out: a=255, b=1, cin=0, sub=0.
  - Required: result=0, cout=1, done exactly 8 cycles after start, busy high for 8 cycles.
- Add, no carry: a=244, b=11, cin=0 → result=255, cout=0.
- Signed overflow (macro on): a=127, b=1, cin=0 → result=128, cout=0, ovf=1.
  - Also a=6, b=5 → result=11, ovf=0.
- Subtract: sub=1, a=6, b=5, cin=0 → result=1, cout=1.
  - Immediately follow with start on the done cycle: a=5, b=6 → result=255, cout=0, done 8 cycles later.
- Start ignored during RUN: a=10, b=20; at cycle 3 pulse start with a=0, b=0.
  - Required: result=30, a single done pulse, and result=30 held for 20 idle cycles afterwards.
- Reset mid-operation: start a=255, b=255; drop rst_n at cycle 4.
  - Required: busy, done, result and cout go to 0 at once, and no done appears.
  - After release, a=1, b=2 → result=3.

Source files
------------

// File: rtl/serial_add_sub_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_add_sub_if                                                          |
// | Start/done operand and result bundle for the bit-serial adder/subtractor.  |
// | ovf exists only when SERIAL_ADD_SUB_OVF_EN is defined.                     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b, cin,
                  input  busy, done, result, cout, ovf);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, result, cout, ovf);
`else
  modport master (output start, sub, a, b, cin,
                  input  busy, done, result, cout);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, result, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_add_sub                                                             |
// | Bit-serial two's-complement add/subtract, one full-adder slice, LSB first. |
// | Optional signed overflow output: define SERIAL_ADD_SUB_OVF_EN.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  wire              clk,
  input  wire              rst_n,
  serial_add_sub_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [WIDTH-2:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_done;

  logic             w_bb;
  logic             w_sum;
  logic             w_cy;
  logic [WIDTH-1:0] w_acc_next;

  // Single full-adder slice; b is inverted for subtraction.
  assign w_bb       = r_b[0] ^ r_sub;
  assign w_sum      = r_a[0] ^ w_bb ^ r_carry;
  assign w_cy       = (r_a[0] & w_bb) | (r_carry & (r_a[0] ^ w_bb));
  assign w_acc_next = {w_sum, r_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_sub   <= bus.sub;
        // Sub computes a + ~b + !cin, so the initial carry is cin ^ sub.
        r_carry <= bus.cin ^ bus.sub;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_cy;
        r_acc   <= w_acc_next[WIDTH-1:1];
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_result <= w_acc_next;
          r_cout   <= w_cy;
`ifdef SERIAL_ADD_SUB_OVF_EN
          // r_carry is the carry into the MSB on the final bit.
          r_ovf    <= r_carry ^ w_cy;
`endif
        end
      end
    end
  end

  assign bus.busy   = (r_state == RUN);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign bus.ovf    = r_ovf;
`endif

endmodule
`default_nettype wire
